// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, default widths and jump-LUT contents for the fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int DEF_PC_W      = 10;
  localparam int DEF_LUT_AW    = 5;
  localparam int DEF_LUT_DEPTH = 1 << DEF_LUT_AW;

  // Entries double as absolute targets and as two's-complement relative offsets.
  localparam logic [DEF_PC_W-1:0] JUMP_LUT [DEF_LUT_DEPTH] = '{
    10'd0,  10'd20, 10'h3FC, 10'd5, 10'd0, 10'd0, 10'd0, 10'd0,
    10'd0,  10'd0,  10'd0,   10'd0, 10'd0, 10'd0, 10'd0, 10'd0,
    10'd0,  10'd0,  10'd0,   10'd0, 10'd0, 10'd0, 10'd0, 10'd0,
    10'd0,  10'd0,  10'd0,   10'd0, 10'd0, 10'd0, 10'd0, 10'd0
  };

endpackage

// File: rtl/jump_lut.sv
// rtl/jump_lut.sv - combinational jump-target ROM indexed by the instruction LUT field
module jump_lut
  import fetch_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int LUT_AW = DEF_LUT_AW
) (
  input  logic [LUT_AW-1:0] idx,
  output logic [PC_W-1:0]   value
);

  // Pure table read; no registering so the branch resolves in the same cycle.
  always_comb begin
    value = PC_W'(JUMP_LUT[idx]);
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - program counter, start/run/halt sequencing and retired-instruction counter
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int LUT_AW = DEF_LUT_AW,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Stall,
  input  logic              Halt_req,
  input  logic              Branch_en,
  input  logic              Branch_cond,
  input  logic              Branch_abs,
  input  logic [LUT_AW-1:0] Lut_idx,
  output logic [PC_W-1:0]   PC,
  output logic              Fetch_valid,
  output logic              Halt,
  output logic [CNT_W-1:0]  Inst_count
);

  fetch_state_t     state, state_next;
  logic             halt_q;
  logic [PC_W-1:0]  pc_q, pc_next;
  logic [CNT_W-1:0] cnt_q, cnt_next, cnt_inc;
  logic [PC_W-1:0]  lut_value;
  logic             take_branch;

  jump_lut #(
    .PC_W   (PC_W),
    .LUT_AW (LUT_AW)
  ) u_jump_lut (
    .idx   (Lut_idx),
    .value (lut_value)
  );

  assign take_branch = Branch_en & Branch_cond;
  // Counter sticks at all-ones instead of wrapping.
  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // State register; Halt is a flop loaded with the upcoming HALTED decode so it is glitch-free.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      halt_q <= 1'b0;
    end else begin
      state  <= state_next;
      halt_q <= (state_next == HALTED);
    end
  end

  // Next-state selection: Start restarts from anywhere, Stall freezes RUN, Halt_req ends it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!Start) state_next = RUN;
      end
      RUN: begin
        if (Start)         state_next = IDLE;
        else if (Stall)    state_next = RUN;
        else if (Halt_req) state_next = HALTED;
      end
      HALTED: begin
        if (Start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: a fetch is only meaningful while running and not frozen.
  always_comb begin
    Fetch_valid = (state == RUN) && !Stall;
    Halt        = halt_q;
    PC          = pc_q;
    Inst_count  = cnt_q;
  end

  // PC and counter update; the halting instruction retires but its address stays on PC.
  always_comb begin
    pc_next  = pc_q;
    cnt_next = cnt_q;
    case (state)
      IDLE: begin
        pc_next  = '0;
        cnt_next = '0;
      end
      RUN: begin
        if (Start) begin
          pc_next  = '0;
          cnt_next = '0;
        end else if (!Stall) begin
          cnt_next = cnt_inc;
          if (Halt_req)                     pc_next = pc_q;
          else if (take_branch && Branch_abs) pc_next = lut_value;
          else if (take_branch)             pc_next = pc_q + lut_value;
          else                              pc_next = pc_q + PC_W'(1);
        end
      end
      HALTED: begin
        if (Start) begin
          pc_next  = '0;
          cnt_next = '0;
        end
      end
      default: begin
        pc_next  = '0;
        cnt_next = '0;
      end
    endcase
  end

  // PC and counter registers, cleared asynchronously with the FSM.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_next;
      cnt_q <= cnt_next;
    end
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Program-counter and instruction-fetch control stage that drives the instruction ROM address (PC) and the top-level halt flag.
- Sits directly upstream of the instruction ROM and decoder inside TopLevel.
- Sequences the start / run / halt protocol:
  - Start held high means park at PC 0.
  - Start low means run.
  - A decoded halt instruction raises halt.
- Resolves absolute and relative branches through a jump lookup table and maintains a retired-instruction counter.

Parameters:
PC_W, 10, program counter width in bits (ROM depth 2^PC_W)
LUT_AW, 5, jump-LUT index width (2^LUT_AW entries)
CNT_W, 16, retired-instruction counter width

Ports:
CLK  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Start  input  1  high = hold in IDLE with PC=0; falling to low launches program
Stall  input  1  high = freeze PC, counter and state this cycle
Halt_req  input  1  current instruction decodes as halt
Branch_en  input  1  current instruction is a conditional branch
Branch_cond  input  1  branch condition flag from ALU/flag register
Branch_abs  input  1  1 = absolute target, 0 = PC-relative offset
Lut_idx  input  LUT_AW  jump-LUT index from instruction field
PC  output  PC_W  instruction ROM address
Fetch_valid  output  1  high while in RUN and not stalled
Halt  output  1  program done flag
Inst_count  output  CNT_W  instructions retired since launch

Behaviour:
- Single clock CLK; Reset is asynchronous, active-high.
- Reset asserted: state=IDLE, PC=0, Halt=0, Inst_count=0, Fetch_valid=0, immediately, without waiting for a clock edge.
- All other state updates occur on the rising edge of CLK.
- States: IDLE, RUN, HALTED (encoded in package enum).
- IDLE:
  - PC=0, Halt=0, Inst_count held at 0.
  - Start=1: stay in IDLE.
  - Start=0: go to RUN next edge, with PC still 0.
  - The first instruction fetched is at address 0.
- RUN, per edge, first matching rule wins:
  1. Start=1 -> IDLE; PC=0, Inst_count=0.
  2. Stall=1 -> hold everything; Halt_req and branch inputs ignored.
  3. Halt_req=1 -> HALTED; PC holds the halt instruction address; Inst_count+1.
  4. Branch_en & Branch_cond & Branch_abs -> PC<=LUT[Lut_idx]; Inst_count+1.
  5. Branch_en & Branch_cond & !Branch_abs -> PC<=PC+LUT[Lut_idx], LUT value treated as two's-complement PC_W bits, result mod 2^PC_W; Inst_count+1.
  6. Otherwise -> PC<=PC+1 mod 2^PC_W (wrap 2^PC_W-1 -> 0); Inst_count+1.
  - A branch with Branch_cond=0 behaves as rule 6.
- HALTED:
  - Halt=1, PC frozen, Inst_count frozen, Fetch_valid=0.
  - Start=1 -> IDLE next edge: Halt=0, PC=0, Inst_count=0.
  - Reset also clears it.
  - All other inputs are ignored.
- Fetch_valid = (state==RUN) & !Stall, combinational.
- Halt is registered (state==HALTED); it rises on the edge that takes Halt_req.
- Latency: PC change is visible one edge after the controlling inputs are sampled.
- Inst_count saturates at 2^CNT_W-1; it does not wrap.
- Reset mid-RUN or mid-HALTED: immediate return to IDLE values; the outcome is independent of Start.
- Start re-asserted mid-program: treated as a synchronous restart per rule 1.

Decomposition:
- Package fetch_pkg holds:
  - state enum fetch_state_t {IDLE, RUN, HALTED}
  - PC_W/LUT_AW defaults
  - jump-LUT contents array JUMP_LUT, with entries [0]=0, [1]=20, [2]=10'h3FC (-4), [3]=5, rest 0
- Sub-module jump_lut: combinational ROM, Lut_idx -> PC_W-bit value read from JUMP_LUT.
- inst_fetch holds the FSM, PC register and counter.

Test Plan:
- Reset pulse, then Start=1 for 2 cycles and Start=0 -> PC=0 while Start high; PC=0,1,2,3 on successive edges; Fetch_valid=1.
- At PC=7, drive Branch_en=1, Branch_cond=1, Branch_abs=1, Lut_idx=1 -> next PC=20. Then Branch_abs=0, Lut_idx=2 -> PC=16. Then Branch_cond=0 -> PC=17.
- At PC=1023, no branch -> PC wraps to 0. Relative branch at PC=2 with Lut_idx=2 -> PC=1022.
- Stall=1 for 3 cycles at PC=5 with Halt_req=1 -> PC stays 5, Inst_count unchanged, Halt=0. Releasing Stall -> Halt=1 next edge, PC=5.
- Run 6 instructions then Halt_req -> Inst_count=7 and Halt=1 stable for 10 cycles. Start=1 -> Halt=0, PC=0, Inst_count=0.
- Assert Reset asynchronously between edges at PC=12 -> PC=0 and Halt=0 before the next CLK edge. With Start=0, RUN resumes at PC 0 after Reset drops.
